rf_writeback: RTL

- Producer side of the 32x32 register-file write port.
- Merges single-cycle ALU results and in-order multi-cycle load responses into one registered write stream: write_enable / rd / data_write.
- Formats load data (byte/half select, sign/zero extension).
- Keeps a pending-load scoreboard so the operand-fetch stage can stall reads of registers whose load has not yet written back.

---
 rtl/rf_writeback.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rf_writeback.sv
// Register-file write-port producer: merges ALU results and in-order load
// responses into one registered write stream, formats load data, and tracks
// pending destination registers so operand fetch can stall on them.
module rf_writeback #(
  parameter int LD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue_valid,
  input  logic [4:0]  ld_issue_rd,
  input  logic [2:0]  ld_issue_funct3,
  input  logic [1:0]  ld_issue_addr_lo,
  output logic        ld_issue_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        write_enable,
  output logic [4:0]  rd,
  output logic [31:0] data_write,
  output logic        protocol_err
);

  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [4:0]          entRd_q [LD_DEPTH];
  logic [2:0]          entF3_q [LD_DEPTH];
  logic [1:0]          entLo_q [LD_DEPTH];
  logic [LD_DEPTH-1:0] entVld_q;
  logic [PW-1:0]       wrPtr_q, rdPtr_q;
  logic [CW-1:0]       count_q;

  logic        holdVld_q;
  logic [4:0]  holdRd_q;
  logic [31:0] holdData_q;

  logic        we_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;
  logic        err_q;

  logic        empty, full, push, ldResp;
  logic [4:0]  headRd;
  logic [2:0]  headF3;
  logic [1:0]  headLo;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;
  logic [31:0] ldData;
  logic        winVld, parkAlu, holdClr;
  logic [4:0]  winRd;
  logic [31:0] winData;
  logic        hit1, hit2;

  assign empty          = (count_q == '0);
  assign full           = (count_q == CW'(LD_DEPTH));
  assign ld_issue_ready = !full;
  assign alu_ready      = !holdVld_q;
  assign push           = ld_issue_valid && !full;
  assign ldResp         = mem_rvalid && !empty;
  assign headRd         = entRd_q[rdPtr_q];
  assign headF3         = entF3_q[rdPtr_q];
  assign headLo         = entLo_q[rdPtr_q];

  assign write_enable = we_q;
  assign rd           = rd_q;
  assign data_write   = data_q;
  assign protocol_err = err_q;

  // Select and extend the byte/half of the raw memory word named by the head entry
  always_comb begin
    byteVal = mem_rdata[7:0];
    case (headLo)
      2'd0: byteVal = mem_rdata[7:0];
      2'd1: byteVal = mem_rdata[15:8];
      2'd2: byteVal = mem_rdata[23:16];
      2'd3: byteVal = mem_rdata[31:24];
      default: byteVal = mem_rdata[7:0];
    endcase
    halfVal = headLo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (headF3)
      3'b000:  ldData = {{24{byteVal[7]}}, byteVal};
      3'b100:  ldData = {24'b0, byteVal};
      3'b001:  ldData = {{16{halfVal[15]}}, halfVal};
      3'b101:  ldData = {16'b0, halfVal};
      default: ldData = mem_rdata;
    endcase
  end

  // Priority: load response, then parked ALU result, then live ALU result
  always_comb begin
    winVld  = 1'b0;
    winRd   = '0;
    winData = '0;
    parkAlu = 1'b0;
    holdClr = 1'b0;
    if (ldResp) begin
      winVld  = 1'b1;
      winRd   = headRd;
      winData = ldData;
      parkAlu = alu_valid && alu_ready;
    end else if (holdVld_q) begin
      winVld  = 1'b1;
      winRd   = holdRd_q;
      winData = holdData_q;
      holdClr = 1'b1;
    end else if (alu_valid) begin
      winVld  = 1'b1;
      winRd   = alu_rd;
      winData = alu_data;
    end
  end

  // Pending-write lookup for both operand-fetch ports
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (entVld_q[i] && (entRd_q[i] == rs1)) hit1 = 1'b1;
      if (entVld_q[i] && (entRd_q[i] == rs2)) hit2 = 1'b1;
    end
    if (holdVld_q && (holdRd_q == rs1)) hit1 = 1'b1;
    if (holdVld_q && (holdRd_q == rs2)) hit2 = 1'b1;
    rs1_busy = (rs1 != 5'd0) && hit1;
    rs2_busy = (rs2 != 5'd0) && hit2;
  end

  // Load queue: push at the tail on issue, pop the head on a response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LD_DEPTH; i++) begin
        entRd_q[i] <= '0;
        entF3_q[i] <= '0;
        entLo_q[i] <= '0;
      end
      entVld_q <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
    end else begin
      if (ldResp) begin
        entVld_q[rdPtr_q] <= 1'b0;
        rdPtr_q           <= rdPtr_q + 1'b1;
      end
      if (push) begin
        entRd_q[wrPtr_q]  <= ld_issue_rd;
        entF3_q[wrPtr_q]  <= ld_issue_funct3;
        entLo_q[wrPtr_q]  <= ld_issue_addr_lo;
        entVld_q[wrPtr_q] <= 1'b1;
        wrPtr_q           <= wrPtr_q + 1'b1;
      end
      case ({push, ldResp})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Hold register parks an ALU result that lost to a load response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      holdVld_q  <= 1'b0;
      holdRd_q   <= '0;
      holdData_q <= '0;
    end else if (parkAlu) begin
      holdVld_q  <= 1'b1;
      holdRd_q   <= alu_rd;
      holdData_q <= alu_data;
    end else if (holdClr) begin
      holdVld_q  <= 1'b0;
    end
  end

  // Registered write port; x0 winners are consumed without a write strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      we_q <= winVld && (winRd != 5'd0);
      if (winVld && (winRd != 5'd0)) begin
        rd_q   <= winRd;
        data_q <= winData;
      end
    end
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (mem_rvalid && empty) begin
      err_q <= 1'b1;
    end
  end

endmodule
